// File: rtl/pc_update_unit.sv
// Next-PC stage: computes the dynamic next PC from the decoded PC-source code,
// owns the architectural PC, sequences the IFU/execute handshake, counts retired
// instructions and traps (terminally, until reset) on a misaligned target.
module pc_update_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
    parameter int unsigned     CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       PC_src,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             branch_taken,
    input  logic             inst_done,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  dnpc,
    output logic             fetch_valid,
    output logic             misalign,
    output logic [CNT_W-1:0] inst_count
);

    // PC-source encodings produced by the upstream decoder
    localparam logic [2:0] SrcPc4    = 3'b000;
    localparam logic [2:0] SrcImm    = 3'b001;
    localparam logic [2:0] SrcJalr   = 3'b010;
    localparam logic [2:0] SrcBranch = 3'b011;
    localparam logic [2:0] SrcJal    = 3'b100;

    typedef enum logic [1:0] {
        StReset = 2'b00,
        StFetch = 2'b01,
        StExec  = 2'b10,
        StTrap  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  inst_count_q, inst_count_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              misalign_q, misalign_d;

    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   pc_plus_imm;
    logic [XLEN-1:0]   jalr_target;
    logic [XLEN-1:0]   dnpc_w;
    logic              target_misaligned;

    // Next-PC candidates and source select; unused/reserved codes fall back to pc+4
    always_comb begin
        pc_plus4    = pc_q + XLEN'(4);
        pc_plus_imm = pc_q + imm;
        jalr_target = {alu_result[XLEN-1:1], 1'b0};
        dnpc_w      = pc_plus4;
        unique case (PC_src)
            SrcPc4:    dnpc_w = pc_plus4;
            SrcImm:    dnpc_w = pc_plus_imm;
            SrcJalr:   dnpc_w = jalr_target;
            SrcBranch: dnpc_w = branch_taken ? pc_plus_imm : pc_plus4;
            SrcJal:    dnpc_w = pc_plus_imm;
            default:   dnpc_w = pc_plus4;
        endcase
        // Checked after jalr bit0 clearing, so only bit1 can trip it for jalr
        target_misaligned = (dnpc_w[1:0] != 2'b00);
    end

    // Handshake sequencing and retire / trap decision
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_count_d = inst_count_q;
        misalign_d   = misalign_q;
        unique case (state_q)
            StReset: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (fetch_ready) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (inst_done) begin
                    if (target_misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = StTrap;
                    end else begin
                        pc_d         = dnpc_w;
                        inst_count_d = inst_count_q + CNT_W'(1);
                        state_d      = StFetch;
                    end
                end
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StReset;
            end
        endcase
        // Registered request: high exactly while the FSM sits in the fetch state
        fetch_valid_d = (state_d == StFetch);
    end

    // All architectural state, asynchronously reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StReset;
            pc_q          <= RESET_PC;
            inst_count_q  <= '0;
            fetch_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_count_q  <= inst_count_d;
            fetch_valid_q <= fetch_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign pc          = pc_q;
    assign dnpc        = dnpc_w;
    assign fetch_valid = fetch_valid_q;
    assign misalign    = misalign_q;
    assign inst_count  = inst_count_q;

    // Structural invariants of the registered outputs
    a_pc_aligned : assert property (@(posedge clk) disable iff (rst)
        pc_q[1:0] == 2'b00);
    a_fetch_valid_state : assert property (@(posedge clk) disable iff (rst)
        fetch_valid_q == (state_q == StFetch));
    a_misalign_state : assert property (@(posedge clk) disable iff (rst)
        misalign_q == (state_q == StTrap));

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit: table of combinational dnpc vectors taken
// while reset holds pc at RESET_PC, then hand-written handshake sequences.
module tb_pc_update_unit;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  PC_src;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        branch_taken;
    logic        inst_done;
    logic        fetch_ready;
    logic [31:0] pc;
    logic [31:0] dnpc;
    logic        fetch_valid;
    logic        misalign;
    logic [31:0] inst_count;

    int n_checks = 0;
    int n_errors = 0;

    pc_update_unit dut (
        .clk          (clk),
        .rst          (rst),
        .PC_src       (PC_src),
        .imm          (imm),
        .alu_result   (alu_result),
        .branch_taken (branch_taken),
        .inst_done    (inst_done),
        .fetch_ready  (fetch_ready),
        .pc           (pc),
        .dnpc         (dnpc),
        .fetch_valid  (fetch_valid),
        .misalign     (misalign),
        .inst_count   (inst_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        bt;
        logic [31:0] exp_dnpc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction: accept the fetch, then complete it with the given source
    task automatic run_inst(input logic [2:0] src, input logic [31:0] im,
                            input logic [31:0] alu, input logic bt);
        check("fv_fetch", {31'd0, fetch_valid}, 32'd1);
        fetch_ready = 1'b1;
        inst_done   = 1'b0;
        tick();
        check("fv_exec", {31'd0, fetch_valid}, 32'd0);
        fetch_ready  = 1'b0;
        PC_src       = src;
        imm          = im;
        alu_result   = alu;
        branch_taken = bt;
        inst_done    = 1'b1;
        tick();
        inst_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3'b000, 32'h0000_0040, 32'h1234_5679, 1'b1, 32'h8000_0004};
        vecs[1]  = '{3'b001, 32'h0000_0100, 32'h0,         1'b0, 32'h8000_0100};
        vecs[2]  = '{3'b001, 32'hFFFF_FFFC, 32'h0,         1'b0, 32'h7FFF_FFFC};
        vecs[3]  = '{3'b010, 32'h0000_0040, 32'h1234_5679, 1'b0, 32'h1234_5678};
        vecs[4]  = '{3'b010, 32'h0,         32'h0000_0003, 1'b1, 32'h0000_0002};
        vecs[5]  = '{3'b011, 32'h0000_0040, 32'h0,         1'b1, 32'h8000_0040};
        vecs[6]  = '{3'b011, 32'h0000_0040, 32'h0,         1'b0, 32'h8000_0004};
        vecs[7]  = '{3'b100, 32'h0000_0800, 32'h0,         1'b0, 32'h8000_0800};
        vecs[8]  = '{3'b100, 32'h8000_0000, 32'h0,         1'b0, 32'h0000_0000};
        vecs[9]  = '{3'b101, 32'h0000_0040, 32'h0000_0101, 1'b1, 32'h8000_0004};
        vecs[10] = '{3'b110, 32'h0000_0040, 32'h0000_0101, 1'b1, 32'h8000_0004};
        vecs[11] = '{3'b111, 32'h0000_0040, 32'h0000_0101, 1'b1, 32'h8000_0004};

        rst = 1'b1; PC_src = 3'b000; imm = '0; alu_result = '0;
        branch_taken = 1'b0; inst_done = 1'b0; fetch_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", pc, RST_PC);
        check("rst_fv", {31'd0, fetch_valid}, 32'd0);
        check("rst_mis", {31'd0, misalign}, 32'd0);
        check("rst_cnt", inst_count, 32'd0);

        // Combinational dnpc with pc pinned at RESET_PC
        for (int i = 0; i < 12; i++) begin
            PC_src = vecs[i].src; imm = vecs[i].imm;
            alu_result = vecs[i].alu; branch_taken = vecs[i].bt;
            #1;
            check($sformatf("dnpc_vec%0d", i), dnpc, vecs[i].exp_dnpc);
        end
        PC_src = 3'b000; imm = '0; alu_result = '0; branch_taken = 1'b0;

        // Release: one idle cycle, then fetch at RESET_PC
        tick();
        rst = 1'b0;
        #1;
        check("idle_fv", {31'd0, fetch_valid}, 32'd0);
        tick();
        check("start_fv", {31'd0, fetch_valid}, 32'd1);
        check("start_pc", pc, RST_PC);
        check("start_cnt", inst_count, 32'd0);

        // Sequential x3
        run_inst(3'b000, 32'h0, 32'h0, 1'b0);
        check("seq1_pc", pc, 32'h8000_0004);
        run_inst(3'b000, 32'h0, 32'h0, 1'b0);
        check("seq2_pc", pc, 32'h8000_0008);
        run_inst(3'b000, 32'h0, 32'h0, 1'b0);
        check("seq3_pc", pc, 32'h8000_000C);
        check("seq3_cnt", inst_count, 32'd3);
        run_inst(3'b000, 32'h0, 32'h0, 1'b0);
        check("seq4_pc", pc, 32'h8000_0010);

        // Branch not taken, branch taken, jal, pc+imm, jalr
        run_inst(3'b011, 32'hFFFF_FFF0, 32'h0, 1'b0);
        check("bnt_pc", pc, 32'h8000_0014);
        run_inst(3'b011, 32'hFFFF_FFEC, 32'h0, 1'b1);
        check("bt_pc", pc, 32'h8000_0000);
        run_inst(3'b100, 32'h0000_0030, 32'h0, 1'b0);
        check("jal_pc", pc, 32'h8000_0030);
        run_inst(3'b001, 32'h0000_0010, 32'h0, 1'b0);
        check("imm_pc", pc, 32'h8000_0040);
        run_inst(3'b010, 32'h0, 32'h8000_0101, 1'b0);
        check("jalr_pc", pc, 32'h8000_0100);
        check("jalr_cnt", inst_count, 32'd9);
        check("jalr_mis", {31'd0, misalign}, 32'd0);

        // Fetch stall with inst_done pulsing: nothing retires
        fetch_ready = 1'b0; inst_done = 1'b1; PC_src = 3'b001; imm = 32'h40;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_fv", {31'd0, fetch_valid}, 32'd1);
            check("stall_pc", pc, 32'h8000_0100);
        end
        check("stall_cnt", inst_count, 32'd9);

        // Exec hold: fetch_ready ignored while inst_done low
        inst_done = 1'b0; fetch_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_fv", {31'd0, fetch_valid}, 32'd0);
            check("hold_pc", pc, 32'h8000_0100);
        end

        // Misaligned jalr target traps (bit1 survives bit0 clearing)
        PC_src = 3'b010; alu_result = 32'h8000_0102; inst_done = 1'b1;
        tick();
        check("trap_mis", {31'd0, misalign}, 32'd1);
        check("trap_pc", pc, 32'h8000_0100);
        check("trap_cnt", inst_count, 32'd9);
        PC_src = 3'b000;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("trap_fv", {31'd0, fetch_valid}, 32'd0);
            check("trap_hold_pc", pc, 32'h8000_0100);
            check("trap_hold_mis", {31'd0, misalign}, 32'd1);
        end
        check("trap_hold_cnt", inst_count, 32'd9);

        // Reset clears the trap asynchronously
        inst_done = 1'b0; fetch_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("trst_pc", pc, RST_PC);
        check("trst_mis", {31'd0, misalign}, 32'd0);
        check("trst_cnt", inst_count, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("trst_idle_fv", {31'd0, fetch_valid}, 32'd0);
        tick();
        check("trst_fv", {31'd0, fetch_valid}, 32'd1);

        // PC wraps modulo 2^32
        run_inst(3'b010, 32'h0, 32'hFFFF_FFFD, 1'b0);
        check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        run_inst(3'b000, 32'h0, 32'h0, 1'b0);
        check("wrap_pc", pc, 32'h0000_0000);
        check("wrap_cnt", inst_count, 32'd2);

        // Async reset during fetch drops fetch_valid without a clock edge
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("afetch_fv", {31'd0, fetch_valid}, 32'd0);
        check("afetch_pc", pc, RST_PC);
        tick();
        rst = 1'b0;
        tick();
        run_inst(3'b000, 32'h0, 32'h0, 1'b0);
        check("pre_aexec_pc", pc, 32'h8000_0004);

        // Async reset mid-exec
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("aexec_pc", pc, RST_PC);
        check("aexec_fv", {31'd0, fetch_valid}, 32'd0);
        check("aexec_cnt", inst_count, 32'd0);
        tick();
        check("aexec_hold_fv", {31'd0, fetch_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
